// File: rtl/mandel_scan_ctrl.sv
// Mandelbrot frame scan controller.
// Walks a pix_x by pix_y pixel grid, column by column (py inner, px outer).
// For each pixel it hands one (cx, cy) job to the iteration core, waits for
// the core's result, turns it into a 3-bit colour and writes that colour to
// the framebuffer.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cfg_*                 : frame configuration, latched on cfg_start in IDLE
//   abort                 : cancels a frame in progress without a done pulse
//   busy, done            : frame active / one-cycle frame-complete pulse
//   job_*                 : valid/ready job request to the iteration core
//   res_*                 : iteration core result (valid only)
//   wx, wy, wd, we        : framebuffer write port
module mandel_scan_ctrl #(
  parameter int unsigned N_BIT = 16,
  parameter int unsigned IW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [7:0]       cfg_pix_x,
  input  logic [7:0]       cfg_pix_y,
  input  logic [N_BIT-1:0] cfg_cxs,
  input  logic [N_BIT-1:0] cfg_cys,
  input  logic [N_BIT-1:0] cfg_dcx,
  input  logic [N_BIT-1:0] cfg_dcy,
  input  logic [IW-1:0]    cfg_max_iter,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             job_valid,
  input  logic             job_ready,
  output logic [N_BIT-1:0] job_cx,
  output logic [N_BIT-1:0] job_cy,
  output logic [IW-1:0]    job_max_iter,
  input  logic             res_valid,
  input  logic [IW-1:0]    res_iter,
  input  logic             res_diverged,
  output logic [8:0]       wx,
  output logic [7:0]       wy,
  output logic [2:0]       wd,
  output logic             we
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       pix_x_q, pix_x_d;
  logic [7:0]       pix_y_q, pix_y_d;
  logic [N_BIT-1:0] cxs_q, cxs_d;
  logic [N_BIT-1:0] cys_q, cys_d;
  logic [N_BIT-1:0] dcx_q, dcx_d;
  logic [N_BIT-1:0] dcy_q, dcy_d;
  logic [IW-1:0]    max_iter_q, max_iter_d;
  logic [7:0]       px_q, px_d;
  logic [7:0]       py_q, py_d;
  logic [N_BIT-1:0] cx_q, cx_d;
  logic [N_BIT-1:0] cy_q, cy_d;
  logic [2:0]       wd_q, wd_d;

  logic [IW-1:0]    iter_mod7;
  logic             py_last;
  logic             px_last;

  // Diverged pixels map onto colours 1..7; bounded pixels are colour 0.
  assign iter_mod7 = res_iter % IW'(7);
  // Dimensions are non-zero whenever a pixel is being written.
  assign py_last   = (py_q == (pix_y_q - 8'd1));
  assign px_last   = (px_q == (pix_x_q - 8'd1));

  // Outputs come straight from registers or from the registered state.
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign job_valid    = (state_q == ISSUE);
  assign we           = (state_q == WRITE);
  assign job_cx       = cx_q;
  assign job_cy       = cy_q;
  assign job_max_iter = max_iter_q;
  assign wx           = {1'b0, px_q};
  assign wy           = py_q;
  assign wd           = wd_q;

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      cxs_q      <= '0;
      cys_q      <= '0;
      dcx_q      <= '0;
      dcy_q      <= '0;
      max_iter_q <= '0;
      px_q       <= '0;
      py_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      cxs_q      <= cxs_d;
      cys_q      <= cys_d;
      dcx_q      <= dcx_d;
      dcy_q      <= dcy_d;
      max_iter_q <= max_iter_d;
      px_q       <= px_d;
      py_q       <= py_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      wd_q       <= wd_d;
    end
  end

  // Next-state and datapath update; abort wins over every other event.
  always_comb begin
    state_d    = state_q;
    pix_x_d    = pix_x_q;
    pix_y_d    = pix_y_q;
    cxs_d      = cxs_q;
    cys_d      = cys_q;
    dcx_d      = dcx_q;
    dcy_d      = dcy_q;
    max_iter_d = max_iter_q;
    px_d       = px_q;
    py_d       = py_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    wd_d       = wd_q;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          pix_x_d    = cfg_pix_x;
          pix_y_d    = cfg_pix_y;
          cxs_d      = cfg_cxs;
          cys_d      = cfg_cys;
          dcx_d      = cfg_dcx;
          dcy_d      = cfg_dcy;
          max_iter_d = cfg_max_iter;
          px_d       = 8'd0;
          py_d       = 8'd0;
          cx_d       = cfg_cxs;
          cy_d       = cfg_cys;
          state_d    = ((cfg_pix_x == 8'd0) || (cfg_pix_y == 8'd0)) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (job_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (res_valid) begin
          wd_d    = res_diverged ? (3'(iter_mod7) + 3'd1) : 3'd0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!py_last) begin
          py_d    = py_q + 8'd1;
          cy_d    = cy_q + dcy_q;
          state_d = ISSUE;
        end else if (!px_last) begin
          py_d    = 8'd0;
          cy_d    = cys_q;
          px_d    = px_q + 8'd1;
          cx_d    = cx_q + dcx_q;
          state_d = ISSUE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// Self-checking bench for mandel_scan_ctrl: a behavioural iteration core,
// a frame model that lists the expected jobs, and monitors that check jobs,
// framebuffer writes and done pulses against scoreboard queues.
module tb_mandel_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [7:0]  cfg_pix_x, cfg_pix_y;
  logic [15:0] cfg_cxs, cfg_cys, cfg_dcx, cfg_dcy;
  logic [7:0]  cfg_max_iter;
  logic        abort;
  logic        busy, done, job_valid, job_ready;
  logic [15:0] job_cx, job_cy;
  logic [7:0]  job_max_iter;
  logic        res_valid, res_diverged;
  logic [7:0]  res_iter;
  logic [8:0]  wx;
  logic [7:0]  wy;
  logic [2:0]  wd;
  logic        we;

  always #5 clk = ~clk;

  mandel_scan_ctrl #(.N_BIT(16), .IW(8)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start),
    .cfg_pix_x(cfg_pix_x), .cfg_pix_y(cfg_pix_y),
    .cfg_cxs(cfg_cxs), .cfg_cys(cfg_cys), .cfg_dcx(cfg_dcx), .cfg_dcy(cfg_dcy),
    .cfg_max_iter(cfg_max_iter), .abort(abort),
    .busy(busy), .done(done),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_cx(job_cx), .job_cy(job_cy), .job_max_iter(job_max_iter),
    .res_valid(res_valid), .res_iter(res_iter), .res_diverged(res_diverged),
    .wx(wx), .wy(wy), .wd(wd), .we(we)
  );

  typedef struct packed {
    logic [15:0] cx;
    logic [15:0] cy;
    logic [7:0]  mi;
    logic [8:0]  x;
    logic [7:0]  y;
  } job_t;

  typedef struct packed {
    logic       div;
    logic [7:0] iter;
    logic [2:0] wd;
  } res_t;

  job_t        job_exp[$];
  logic [16:0] xy_q[$];
  logic [2:0]  col_q[$];
  res_t        forced_q[$];
  int          lat_q[$];
  logic [15:0] hs_cy_log[$];

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int vld_wait = 0;
  bit rand_ready = 1'b0;
  int hold_len = 0;
  int lat_min = 1;
  int lat_max = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [2:0] colour(input logic div, input logic [7:0] it);
    return div ? 3'((it % 8'd7) + 8'd1) : 3'd0;
  endfunction

  // Frame model: one job per pixel, column by column.
  task automatic push_jobs(input int w, input int h, input logic [15:0] cxs,
                           input logic [15:0] cys, input logic [15:0] dcx,
                           input logic [15:0] dcy, input logic [7:0] mi);
    job_t e;
    for (int x = 0; x < w; x++) begin
      for (int y = 0; y < h; y++) begin
        e.cx = cxs + 16'(x) * dcx;
        e.cy = cys + 16'(y) * dcy;
        e.mi = mi;
        e.x  = 9'(x);
        e.y  = 8'(y);
        job_exp.push_back(e);
      end
    end
  endtask

  // Behavioural iteration core: accepts a job, answers after a latency.
  initial begin : core_model
    int   cnt;
    int   held;
    bit   pend;
    res_t r;
    logic [7:0] p_iter;
    logic p_div;
    cnt = 0; held = 0; pend = 1'b0; p_iter = 8'd0; p_div = 1'b0;
    job_ready = 1'b1; res_valid = 1'b0; res_iter = 8'd0; res_diverged = 1'b0;
    forever begin
      @(negedge clk);
      res_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          res_valid = 1'b1; res_iter = p_iter; res_diverged = p_div; pend = 1'b0;
        end
      end
      if (job_valid && held < hold_len) begin
        job_ready = 1'b0;
        held++;
      end else if (rand_ready) begin
        job_ready = ($urandom_range(0, 2) != 0);
      end else begin
        job_ready = 1'b1;
      end
      if (job_valid && job_ready && !pend) begin
        held = 0;
        if (forced_q.size() != 0) begin
          r = forced_q.pop_front();
        end else begin
          r.div  = 1'($urandom_range(0, 1));
          r.iter = 8'($urandom);
          r.wd   = colour(r.div, r.iter);
        end
        p_iter = r.iter;
        p_div  = r.div;
        col_q.push_back(r.wd);
        cnt  = (lat_q.size() != 0) ? lat_q.pop_front() : int'($urandom_range(lat_min, lat_max));
        pend = 1'b1;
      end
    end
  end

  // Job monitor: the offered job must match the model's next pixel.
  initial begin : job_mon
    job_t e;
    forever begin
      @(negedge clk); #1;
      if (job_valid) begin
        if (job_exp.size() == 0) begin
          fail_now("unexpected_job_valid");
        end else begin
          e = job_exp[0];
          chk("job_cx", 64'(job_cx), 64'(e.cx));
          chk("job_cy", 64'(job_cy), 64'(e.cy));
          chk("job_max_iter", 64'(job_max_iter), 64'(e.mi));
          if (!job_ready) vld_wait++;
          if (job_ready && !abort && !rst) begin
            void'(job_exp.pop_front());
            xy_q.push_back({e.x, e.y});
            hs_cy_log.push_back(job_cy);
          end
        end
      end
    end
  end

  // Write monitor: each framebuffer write pairs a handshaken pixel with its colour.
  initial begin : wr_mon
    logic [16:0] xy;
    logic [2:0]  c;
    forever begin
      @(negedge clk); #1;
      if (we) begin
        if (xy_q.size() == 0 || col_q.size() == 0) begin
          fail_now("unexpected_we");
        end else begin
          xy = xy_q.pop_front();
          c  = col_q.pop_front();
          chk("wx", 64'(wx), 64'(xy[16:8]));
          chk("wy", 64'(wy), 64'(xy[7:0]));
          chk("wd", 64'(wd), 64'(c));
        end
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk); #1;
      if (done) done_cnt++;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_job_valid"}, 64'(job_valid), 64'd0);
    chk({tag, "_we"}, 64'(we), 64'd0);
    chk({tag, "_wx_wy_wd"}, 64'({wx, wy, wd}), 64'd0);
    chk({tag, "_job_fields"}, 64'({job_cx, job_cy, job_max_iter}), 64'd0);
  endtask

  task automatic drive_cfg(input logic [7:0] w, input logic [7:0] h, input logic [15:0] cxs,
                           input logic [15:0] cys, input logic [15:0] dcx,
                           input logic [15:0] dcy, input logic [7:0] mi);
    cfg_pix_x = w; cfg_pix_y = h; cfg_cxs = cxs; cfg_cys = cys;
    cfg_dcx = dcx; cfg_dcy = dcy; cfg_max_iter = mi;
  endtask

  // Runs one non-empty frame; cfg is scrambled and re-started mid-frame to show it is ignored.
  task automatic run_frame(input int w, input int h, input logic [15:0] cxs,
                           input logic [15:0] cys, input logic [15:0] dcx,
                           input logic [15:0] dcy, input logic [7:0] mi, output int cyc);
    int d0;
    push_jobs(w, h, cxs, cys, dcx, dcy, mi);
    d0 = done_cnt;
    @(negedge clk);
    drive_cfg(8'(w), 8'(h), cxs, cys, dcx, dcy, mi);
    cfg_start = 1'b1;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        cfg_start = 1'b0;
        chk("frame_busy", 64'(busy), 64'd1);
        drive_cfg(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), 8'($urandom));
      end
      if (cyc == 2) cfg_start = 1'b1;
      if (cyc == 3) cfg_start = 1'b0;
    end
    if (!done) fail_now("frame_timeout");
    repeat (3) @(negedge clk);
    chk("frame_done_count", 64'(done_cnt - d0), 64'd1);
    chk("frame_busy_end", 64'(busy), 64'd0);
    chk("frame_jobs_left", 64'(job_exp.size()), 64'd0);
    chk("frame_writes_left", 64'(xy_q.size()), 64'd0);
    job_exp.delete(); xy_q.delete(); col_q.delete();
  endtask

  initial begin : main
    int cyc, d0, h0, v0;
    res_t r;
    rst = 1'b1; cfg_start = 1'b0; abort = 1'b0;
    drive_cfg(8'd0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Basic 2x2 scan with one-cycle core latency; 3 cycles overhead per pixel.
    run_frame(2, 2, 16'hE000, 16'hF000, 16'h0040, 16'h0040, 8'd64, cyc);
    chk("scan_2x2_cycles", 64'(cyc), 64'd13);

    // Colour mapping with fixed results.
    r = '{div: 1'b0, iter: 8'd100, wd: 3'd0}; forced_q.push_back(r);
    r = '{div: 1'b1, iter: 8'd13,  wd: 3'd7}; forced_q.push_back(r);
    r = '{div: 1'b1, iter: 8'd7,   wd: 3'd1}; forced_q.push_back(r);
    r = '{div: 1'b1, iter: 8'd0,   wd: 3'd1}; forced_q.push_back(r);
    run_frame(1, 4, 16'h1234, 16'h0100, 16'h0001, 16'h0002, 8'd200, cyc);
    chk("colour_results_used", 64'(forced_q.size()), 64'd0);

    // Backpressure: ready held low for 5 cycles, then a single handshake.
    h0 = hs_cy_log.size(); v0 = vld_wait; hold_len = 5;
    run_frame(1, 1, 16'h4321, 16'h8765, 16'h0000, 16'h0000, 8'd17, cyc);
    hold_len = 0;
    chk("bp_wait_cycles", 64'(vld_wait - v0), 64'd5);
    chk("bp_handshakes", 64'(hs_cy_log.size() - h0), 64'd1);

    // Zero-size frames: done in the next cycle only, no job, no write.
    for (int k = 0; k < 2; k++) begin
      d0 = done_cnt;
      @(negedge clk);
      drive_cfg((k == 0) ? 8'd0 : 8'd3, (k == 0) ? 8'd3 : 8'd0,
                16'h1111, 16'h2222, 16'h0001, 16'h0001, 8'd9);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_job_valid", 64'(job_valid), 64'd0);
      @(negedge clk);
      chk("zero_done_after", 64'(done), 64'd0);
      chk("zero_busy_after", 64'(busy), 64'd0);
      repeat (2) @(negedge clk);
      chk("zero_done_count", 64'(done_cnt - d0), 64'd1);
    end

    // Abort during WAIT of pixel (0,1); the late result must be dropped.
    d0 = done_cnt; h0 = hs_cy_log.size();
    push_jobs(2, 2, 16'h0100, 16'h0200, 16'h0010, 16'h0020, 8'd50);
    lat_q.push_back(1); lat_q.push_back(4);
    @(negedge clk);
    drive_cfg(8'd2, 8'd2, 16'h0100, 16'h0200, 16'h0010, 16'h0020, 8'd50);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cyc = 0;
    while (hs_cy_log.size() < h0 + 2 && cyc < 200) begin
      @(negedge clk); #2;
      cyc++;
    end
    if (hs_cy_log.size() < h0 + 2) fail_now("abort_setup_timeout");
    @(negedge clk); #2;
    abort = 1'b1;
    xy_q.delete(); col_q.delete();
    @(negedge clk); #2;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_job_valid", 64'(job_valid), 64'd0);
    repeat (6) begin
      @(negedge clk); #2;
      chk("abort_no_we", 64'(we), 64'd0);
      chk("abort_idle", 64'(busy), 64'd0);
    end
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    job_exp.delete(); xy_q.delete(); col_q.delete();
    run_frame(1, 2, 16'h0A00, 16'h0B00, 16'h0005, 16'h0006, 8'd33, cyc);

    // Reset mid-WRITE, and cy wrapping from 0x7FC0 to 0x8000.
    d0 = done_cnt; h0 = hs_cy_log.size();
    push_jobs(1, 3, 16'h1000, 16'h7FC0, 16'h0000, 16'h0040, 8'd20);
    @(negedge clk);
    drive_cfg(8'd1, 8'd3, 16'h1000, 16'h7FC0, 16'h0000, 16'h0040, 8'd20);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cyc = 0;
    while (!(we && wy == 8'd1) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!(we && wy == 8'd1)) fail_now("rst_write_timeout");
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    job_exp.delete(); xy_q.delete(); col_q.delete();
    repeat (4) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("midrst_no_we", 64'(we), 64'd0);
    if (hs_cy_log.size() >= h0 + 2) chk("wrap_cy", 64'(hs_cy_log[h0 + 1]), 64'h8000);
    else fail_now("wrap_cy_missing");

    // Randomised frames with random backpressure and core latency.
    for (int i = 0; i < 8; i++) begin
      rand_ready = 1'($urandom_range(0, 1));
      lat_min = 1;
      lat_max = int'($urandom_range(1, 4));
      run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                8'($urandom), cyc);
    end
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mandel_scan_ctrl.md
MANDEL_SCAN_CTRL -- requirements
Module: mandel_scan_ctrl

Interface
REQ-001 SHALL have parameter N_BIT, default 16, the Q4.12 coordinate width.
REQ-002 SHALL have parameter IW, default 8, the iteration-count width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port cfg_start, input, 1, a frame start pulse.
REQ-006 SHALL have ports cfg_pix_x and cfg_pix_y, input, 8 each, the frame width and height in pixels.
REQ-007 SHALL have ports cfg_cxs, cfg_cys, cfg_dcx and cfg_dcy, input, N_BIT each, the start coordinates and steps (two's complement).
REQ-008 SHALL have port cfg_max_iter, input, IW, the iteration limit passed to the core.
REQ-009 SHALL have port abort, input, 1, which cancels the frame in progress.
REQ-010 SHALL have ports busy and done, output, 1 each: frame active, and a one-cycle frame-complete pulse.
REQ-011 SHALL have ports job_valid (output, 1), job_ready (input, 1), job_cx and job_cy (output, N_BIT) and job_max_iter (output, IW), forming the job request to the iteration core.
REQ-012 SHALL have ports res_valid (input, 1), res_iter (input, IW) and res_diverged (input, 1), forming the core result.
REQ-013 SHALL have ports wx (output, 9), wy (output, 8), wd (output, 3) and we (output, 1), forming the framebuffer write port.

Function
REQ-014 SHALL implement the states IDLE, ISSUE, WAIT, WRITE and DONE; all outputs are registered or decoded from the registered state.
REQ-015 In IDLE, cfg_start=1 SHALL latch all cfg_* inputs and set px=py=0, cx=cxs and cy=cys.
REQ-016 On that cfg_start, the block SHALL go to DONE if the latched pix_x=0 or pix_y=0, and to ISSUE otherwise.
REQ-017 cfg_start SHALL be ignored outside IDLE; cfg_* changes after latching SHALL have no effect.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 In ISSUE, job_valid=1 with job_cx=cx, job_cy=cy and job_max_iter=latched max_iter; these values SHALL be held stable until job_ready=1.
REQ-020 The cycle with job_valid and job_ready both high SHALL be the handshake, and the next state SHALL be WAIT; job_valid=0 in all other states.
REQ-021 In WAIT, res_valid=1 SHALL register the colour and move to WRITE; res_valid outside WAIT SHALL be ignored.
REQ-022 Colour SHALL be wd=0 when res_diverged=0, and wd=(res_iter mod 7)+1 when res_diverged=1, giving the range 1..7.
REQ-023 In WRITE, we=1 for exactly one cycle with wx={1'b0,px} and wy=py; we=0 in all other states.
REQ-024 Scan order after WRITE SHALL be py inner and px outer: if py≠pix_y-1, then py+1 and cy+dcy.
REQ-025 If py=pix_y-1 and px≠pix_x-1, the block SHALL set py=0, cy=cys, px+1 and cx+dcx.
REQ-026 After WRITE, the next state SHALL be DONE when py=pix_y-1 and px=pix_x-1 (last pixel), and ISSUE otherwise.
REQ-027 cx and cy additions SHALL be N_BIT modular two's complement with wrap-around and no saturation.
REQ-028 DONE SHALL assert done=1 for one cycle and then go to IDLE.
REQ-029 Per-pixel overhead SHALL be 3 cycles beyond the core latency: handshake→WAIT, res_valid→WRITE, WRITE→ISSUE.
REQ-030 abort=1 in ISSUE, WAIT or WRITE SHALL go to IDLE on the next edge with no done pulse and no further we.
REQ-031 abort SHALL have priority over a simultaneous job handshake, res_valid or cfg_start; abort in IDLE or DONE SHALL be ignored.
REQ-032 A late res_valid after abort SHALL be ignored.

Reset
REQ-033 rst=1 SHALL force IDLE and clear busy, done, job_valid, we, wx, wy, wd, job_cx, job_cy, job_max_iter, px, py, cx, cy and all latched config to 0.
REQ-034 rst SHALL have priority over all other inputs, including mid-frame; no we or done SHALL follow it.

Verification
REQ-035 Scan: cfg 2x2, cxs=0xE000, cys=0xF000, dcx=dcy=0x0040, core ready and result 1 cycle later → jobs (E000,F000),(E000,F040),(E040,F000),(E040,F040); writes (0,0),(0,1),(1,0),(1,1); exactly one done.
REQ-036 Colour: results (diverged=0, iter=100)→wd=0; (1,13)→7; (1,7)→1; (1,0)→1.
REQ-037 Backpressure: job_ready held 0 for 5 cycles → job_valid=1 with job_cx/job_cy unchanged throughout; a single handshake on release.
REQ-038 Zero size: cfg_pix_x=0 and cfg_start at cycle N → done=1 only in cycle N+1, no job_valid, no we.
REQ-039 Abort: abort during WAIT of pixel (0,1), then res_valid 3 cycles later → no we, no done, busy=0; a following cfg_start starts at (0,0).
REQ-040 Reset and wrap: rst mid-WRITE → we=0 next cycle and all outputs 0; cys=0x7FC0 with dcy=0x0040 → second job_cy=0x8000.
